// File: rtl/mips_pkg.sv
// Shared MIPS memory-stage types: FSM states and load/store size encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Ports: none (package).
package mips_pkg;

  // Memory-stage sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memState_t;

  // MemReadSelect encodings carried down from decode.
  typedef enum logic [1:0] {
    LW  = 2'b00,
    LB  = 2'b01,
    LBU = 2'b10,
    LH  = 2'b11
  } memReadSel_t;

  // MemWriteSelect encodings carried down from decode.
  typedef enum logic {
    SW = 1'b0,
    SB = 1'b1
  } memWriteSel_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: picks byte/half from a 32-bit bus word and extends it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: rdata (bus word), addr (byte offset addr[1:0]), select (LW/LB/LBU/LH), data (result).
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0]  rdata,
  input  logic [1:0]   addr,
  input  memReadSel_t  select,
  output logic [31:0]  data
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    // Little-endian: offset 0 is the least significant byte lane.
    byteSel = rdata[7:0];
    case (addr)
      2'd0:    byteSel = rdata[7:0];
      2'd1:    byteSel = rdata[15:8];
      2'd2:    byteSel = rdata[23:16];
      default: byteSel = rdata[31:24];
    endcase

    // Only addr[1] picks the half; addr[0] is not meaningful for halfwords.
    halfSel = addr[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (select)
      LB:      data = {{24{byteSel[7]}}, byteSel};
      LBU:     data = {24'h000000, byteSel};
      LH:      data = {{16{halfSel[15]}}, halfSel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS MEM stage: runs one load/store on a req/ack data bus and stalls the pipe meanwhile.
// Latency: memory ops take >= 3 cycles (IDLE, BUSY until ack, DONE); ALU results pass through combinationally.
// Backpressure: StallOutput is high from request acceptance until ack; mem_ack low holds the block in BUSY.
// Ports: clk, rst (async active-low); EX/MEM inputs (EXResultInput, RegDataBInput, MemRead/Write*,
//        RegDest/RegWrite/MemToReg); bus mem_req/mem_we/mem_addr/mem_wdata/mem_be out, mem_ack/mem_rdata in;
//        StallOutput, WBDataOutput, RegDestOutput, RegWriteOutput, ExcAdELOutput, ExcAdESOutput out.
// Build option: define MEM_ALIGN_CHECK_EN to enable LW/SW/LH alignment exceptions.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       EXResultInput,
  input  logic [31:0]       RegDataBInput,
  input  logic              MemReadInput,
  input  logic              MemWriteInput,
  input  logic [1:0]        MemReadSelectInput,
  input  logic              MemWriteSelectInput,
  input  logic [5:0]        RegDestInput,
  input  logic              RegWriteInput,
  input  logic              MemToRegInput,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              StallOutput,
  output logic [31:0]       WBDataOutput,
  output logic [5:0]        RegDestOutput,
  output logic              RegWriteOutput,
  output logic              ExcAdELOutput,
  output logic              ExcAdESOutput
);

  memState_t    state, nextState;
  memReadSel_t  readSel, readSelQ;
  memWriteSel_t writeSel;

  logic [ADDR_W-1:0] effAddr;
  logic              isStore, isLoad, isLoadQ;
  logic              addrErr, start;
  logic [3:0]        beNext;
  logic [31:0]       wdataNext;
  logic [1:0]        addrLoQ;
  logic [31:0]       captureQ;
  logic [31:0]       loadData;
  logic              unusedMemToReg;

  // Register-file source selection happens in MEM/WB; the load path here keys off the latched read.
  assign unusedMemToReg = MemToRegInput;

  assign effAddr  = ADDR_W'(EXResultInput);
  assign readSel  = memReadSel_t'(MemReadSelectInput);
  assign writeSel = memWriteSel_t'(MemWriteSelectInput);
  // A simultaneous read+write request is treated as a write only.
  assign isStore  = MemWriteInput;
  assign isLoad   = MemReadInput & ~MemWriteInput;

`ifdef MEM_ALIGN_CHECK_EN
  assign ExcAdELOutput = isLoad &&
                         (((readSel == LW) && (effAddr[1:0] != 2'b00)) ||
                          ((readSel == LH) && effAddr[0]));
  assign ExcAdESOutput = isStore && (writeSel == SW) && (effAddr[1:0] != 2'b00);
`else
  assign ExcAdELOutput = 1'b0;
  assign ExcAdESOutput = 1'b0;
`endif

  assign addrErr = ExcAdELOutput | ExcAdESOutput;
  assign start   = (state == IDLE) && (MemReadInput || MemWriteInput) && !addrErr;

  // SB drives one lane and replicates the byte so the slave can take any lane.
  assign beNext    = (isStore && (writeSel == SB)) ? (4'b0001 << effAddr[1:0]) : BE_ALL;
  assign wdataNext = (writeSel == SB) ? {4{RegDataBInput[7:0]}} : RegDataBInput;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState   = state;
    StallOutput = 1'b0;
    case (state)
      IDLE: begin
        // Stall goes up in the accepting cycle so EX/MEM holds the instruction.
        if (start) begin
          nextState   = BUSY;
          StallOutput = 1'b1;
        end
      end
      BUSY: begin
        StallOutput = 1'b1;
        if (mem_ack) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Bus request registers and load capture; address/data are held for the whole of BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      captureQ  <= '0;
      addrLoQ   <= 2'b00;
      readSelQ  <= LW;
      isLoadQ   <= 1'b0;
    end else if (start) begin
      mem_req  <= 1'b1;
      mem_we   <= isStore;
      mem_addr <= {effAddr[ADDR_W-1:2], 2'b00};
      mem_be   <= beNext;
      if (isStore) mem_wdata <= wdataNext;
      addrLoQ  <= effAddr[1:0];
      readSelQ <= readSel;
      isLoadQ  <= isLoad;
    end else if ((state == BUSY) && mem_ack) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      captureQ <= mem_rdata;
    end
  end

  load_extend uLoadExtend (
    .rdata  (captureQ),
    .addr   (addrLoQ),
    .select (readSelQ),
    .data   (loadData)
  );

  assign WBDataOutput   = ((state == DONE) && isLoadQ) ? loadData : EXResultInput;
  assign RegDestOutput  = RegDestInput;
  assign RegWriteOutput = RegWriteInput & ~addrErr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus/WB items, a monitor pops and compares.
// Latency: n/a (testbench).
// Backpressure: bench drives mem_ack after a per-vector delay.
module tb_mem_access_unit;
  import mips_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       EXResultInput, RegDataBInput;
  logic              MemReadInput, MemWriteInput;
  logic [1:0]        MemReadSelectInput;
  logic              MemWriteSelectInput;
  logic [5:0]        RegDestInput;
  logic              RegWriteInput, MemToRegInput;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              StallOutput;
  logic [31:0]       WBDataOutput;
  logic [5:0]        RegDestOutput;
  logic              RegWriteOutput, ExcAdELOutput, ExcAdESOutput;

  int nCmp = 0;
  int nErr = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } busExp_t;

  typedef struct {
    logic        chk;
    logic [31:0] val;
  } wbExp_t;

  busExp_t busQ[$];
  wbExp_t  wbQ[$];

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .EXResultInput       (EXResultInput),
    .RegDataBInput       (RegDataBInput),
    .MemReadInput        (MemReadInput),
    .MemWriteInput       (MemWriteInput),
    .MemReadSelectInput  (MemReadSelectInput),
    .MemWriteSelectInput (MemWriteSelectInput),
    .RegDestInput        (RegDestInput),
    .RegWriteInput       (RegWriteInput),
    .MemToRegInput       (MemToRegInput),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_be              (mem_be),
    .mem_ack             (mem_ack),
    .mem_rdata           (mem_rdata),
    .StallOutput         (StallOutput),
    .WBDataOutput        (WBDataOutput),
    .RegDestOutput       (RegDestOutput),
    .RegWriteOutput      (RegWriteOutput),
    .ExcAdELOutput       (ExcAdELOutput),
    .ExcAdESOutput       (ExcAdESOutput)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    MemReadInput        = 1'b0;
    MemWriteInput       = 1'b0;
    MemReadSelectInput  = 2'b00;
    MemWriteSelectInput = 1'b0;
    RegWriteInput       = 1'b0;
    MemToRegInput       = 1'b0;
    RegDestInput        = 6'd0;
    EXResultInput       = 32'h0;
  endtask

  // Issue one memory instruction; ack rises in BUSY cycle number ackDelay (1-based).
  task automatic runMem(input string name, input logic rd, input logic wr,
                        input logic [1:0] rsel, input logic wsel,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input int ackDelay, input int expStall,
                        input logic [31:0] expAddr, input logic [3:0] expBe, input logic [31:0] expWdata,
                        input logic chkWb, input logic [31:0] expWb);
    busExp_t b;
    wbExp_t  w;
    int      stalls;
    int      c;
    bit      done;
    b.addr = expAddr; b.be = expBe; b.wdata = expWdata; b.we = wr;
    w.chk = chkWb; w.val = expWb;
    busQ.push_back(b);
    wbQ.push_back(w);
    @(posedge clk); #1;
    EXResultInput       = addr;
    RegDataBInput       = wdata;
    MemReadInput        = rd;
    MemWriteInput       = wr;
    MemReadSelectInput  = rsel;
    MemWriteSelectInput = wsel;
    RegWriteInput       = rd & ~wr;
    MemToRegInput       = rd & ~wr;
    RegDestInput        = 6'd9;
    mem_rdata           = rdata;
    mem_ack             = 1'b0;
    stalls = 0;
    c      = 0;
    done   = 1'b0;
    while (!done && c < 40) begin
      if (c > 0) mem_ack = (c == ackDelay);
      @(negedge clk);
      if (c == 0) check({name, "_regwrite"}, 32'(RegWriteOutput), 32'(rd & ~wr));
      if (StallOutput) stalls++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clk); #1;
        c++;
      end
    end
    if (!done) begin
      nCmp++; nErr++;
      $display("FAIL %s_timeout: still stalled after %0d cycles, required completion", name, c);
    end
    check({name, "_stalls"}, 32'(stalls), 32'(expStall));
    @(posedge clk); #1;
    setIdle();
    mem_ack = 1'b0;
  endtask

  // Monitor: pops expectations when a bus request starts and when the stall drops (DONE).
  initial begin
    busExp_t cur;
    wbExp_t  w;
    bit      prevReq;
    bit      prevStall;
    prevReq   = 1'b0;
    prevStall = 1'b0;
    cur.addr = '0; cur.be = '0; cur.wdata = '0; cur.we = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prevReq   = 1'b0;
        prevStall = 1'b0;
      end else begin
        if (mem_req && !prevReq) begin
          if (busQ.size() == 0) begin
            nCmp++; nErr++;
            $display("FAIL bus_unexpected: mem_req=1 addr=0x%08h, required no request", 32'(mem_addr));
          end else begin
            cur = busQ.pop_front();
            check("bus_addr", 32'(mem_addr), cur.addr);
            check("bus_be", 32'(mem_be), 32'(cur.be));
            check("bus_we", 32'(mem_we), 32'(cur.we));
            if (cur.we) check("bus_wdata", mem_wdata, cur.wdata);
          end
        end
        if (mem_req && mem_ack) begin
          check("held_addr", 32'(mem_addr), cur.addr);
          check("held_be", 32'(mem_be), 32'(cur.be));
        end
        if (prevStall && !StallOutput) begin
          if (wbQ.size() == 0) begin
            nCmp++; nErr++;
            $display("FAIL done_unexpected: stall dropped with WB=0x%08h, required no completion", WBDataOutput);
          end else begin
            w = wbQ.pop_front();
            if (w.chk) check("wb_data", WBDataOutput, w.val);
          end
        end
        prevReq   = mem_req;
        prevStall = StallOutput;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    setIdle();
    RegDataBInput = 32'h0;
    mem_ack       = 1'b0;
    mem_rdata     = 32'h0;
    #1 rst = 1'b0;
    #2;
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_be", 32'(mem_be), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_capture", dut.captureQ, 32'h0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_stall", 32'(StallOutput), 32'h0);
    check("rst_excl", 32'(ExcAdELOutput), 32'h0);
    check("rst_excs", 32'(ExcAdESOutput), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // ALU op: no stall, result straight through in the same cycle.
    @(posedge clk); #1;
    EXResultInput = 32'h0000_1234;
    RegWriteInput = 1'b1;
    RegDestInput  = 6'd5;
    #1;
    check("alu_wb", WBDataOutput, 32'h0000_1234);
    check("alu_stall", 32'(StallOutput), 32'h0);
    check("alu_dest", 32'(RegDestOutput), 32'd5);
    check("alu_regwrite", 32'(RegWriteOutput), 32'h1);
    @(negedge clk);
    check("alu_stall_neg", 32'(StallOutput), 32'h0);
    @(posedge clk); #1;
    setIdle();

    //      name    rd    wr    rsel wsel addr          wdata         rdata         ack stl expAddr       be       expWdata      chk   expWb
    runMem("sw",    1'b0, 1'b1, LW,  SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        2,  3,  32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0);
    runMem("lb",    1'b1, 1'b0, LB,  SW,  32'h0000_0103, 32'h0,        32'h8000_0000, 1,  2,  32'h0000_0100, 4'b1111, 32'h0,        1'b1, 32'hFFFF_FF80);
    runMem("lbu",   1'b1, 1'b0, LBU, SW,  32'h0000_0103, 32'h0,        32'h8000_0000, 1,  2,  32'h0000_0100, 4'b1111, 32'h0,        1'b1, 32'h0000_0080);
    runMem("sb",    1'b0, 1'b1, LW,  SB,  32'h0000_0102, 32'h0000_00AB, 32'h0,        1,  2,  32'h0000_0100, 4'b0100, 32'hABAB_ABAB, 1'b0, 32'h0);
    runMem("lh_hi", 1'b1, 1'b0, LH,  SW,  32'h0000_0102, 32'h0,        32'h8001_7FFF, 1,  2,  32'h0000_0100, 4'b1111, 32'h0,        1'b1, 32'hFFFF_8001);
    runMem("lh_lo", 1'b1, 1'b0, LH,  SW,  32'h0000_0100, 32'h0,        32'h8001_7FFF, 2,  3,  32'h0000_0100, 4'b1111, 32'h0,        1'b1, 32'h0000_7FFF);
    runMem("lw",    1'b1, 1'b0, LW,  SW,  32'h0000_0104, 32'h0,        32'hCAFE_F00D, 3,  4,  32'h0000_0104, 4'b1111, 32'h0,        1'b1, 32'hCAFE_F00D);
    runMem("lb_b1", 1'b1, 1'b0, LB,  SW,  32'h0000_0101, 32'h0,        32'h1234_5678, 1,  2,  32'h0000_0100, 4'b1111, 32'h0,        1'b1, 32'h0000_0056);
    runMem("rw",    1'b1, 1'b1, LW,  SW,  32'h0000_0108, 32'h1122_3344, 32'h5555_5555, 1,  2,  32'h0000_0108, 4'b1111, 32'h1122_3344, 1'b0, 32'h0);

    // Reset in BUSY: transfer is dropped and later acks are ignored.
    begin
      busExp_t b;
      b.addr = 32'h0000_0200; b.be = 4'b1111; b.wdata = 32'h0; b.we = 1'b0;
      busQ.push_back(b);
    end
    @(posedge clk); #1;
    EXResultInput      = 32'h0000_0200;
    MemReadInput       = 1'b1;
    MemReadSelectInput = LW;
    RegWriteInput      = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_req", 32'(mem_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rstbusy_req", 32'(mem_req), 32'h0);
    check("rstbusy_state", 32'(dut.state), 32'(IDLE));
    check("rstbusy_addr", 32'(mem_addr), 32'h0);
    check("rstbusy_be", 32'(mem_be), 32'h0);
    setIdle();
    @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("postrst_req", 32'(mem_req), 32'h0);
      check("postrst_stall", 32'(StallOutput), 32'h0);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned LW: exception, no request, no stall, register write suppressed.
    @(posedge clk); #1;
    EXResultInput      = 32'h0000_0101;
    MemReadInput       = 1'b1;
    MemReadSelectInput = LW;
    RegWriteInput      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mis_lw_excl", 32'(ExcAdELOutput), 32'h1);
      check("mis_lw_excs", 32'(ExcAdESOutput), 32'h0);
      check("mis_lw_stall", 32'(StallOutput), 32'h0);
      check("mis_lw_regwrite", 32'(RegWriteOutput), 32'h0);
      check("mis_lw_req", 32'(mem_req), 32'h0);
    end
    @(posedge clk); #1;
    MemReadSelectInput = LH;
    @(negedge clk);
    check("mis_lh_excl", 32'(ExcAdELOutput), 32'h1);
    check("mis_lh_req", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    setIdle();
    EXResultInput       = 32'h0000_0102;
    MemWriteInput       = 1'b1;
    MemWriteSelectInput = SW;
    RegWriteInput       = 1'b1;
    @(negedge clk);
    check("mis_sw_excs", 32'(ExcAdESOutput), 32'h1);
    check("mis_sw_excl", 32'(ExcAdELOutput), 32'h0);
    check("mis_sw_stall", 32'(StallOutput), 32'h0);
    check("mis_sw_regwrite", 32'(RegWriteOutput), 32'h0);
    @(negedge clk);
    check("mis_sw_req", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    setIdle();
`else
    // Without alignment checking, LW ignores addr[1:0] and reads the aligned word.
    runMem("lw_unal", 1'b1, 1'b0, LW, SW, 32'h0000_0101, 32'h0, 32'hA55A_1234, 1, 2, 32'h0000_0100, 4'b1111, 32'h0, 1'b1, 32'hA55A_1234);
    check("noalign_excl", 32'(ExcAdELOutput), 32'h0);
`endif

    repeat (3) @(negedge clk);
    check("busq_empty", 32'(busQ.size()), 32'h0);
    check("wbq_empty", 32'(wbQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
